// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock first-word-fall-through FIFO controller for an external dpram.
// Define SYNC_FIFO_WATERMARK_EN to add the peak_count/clear_peak occupancy watermark.
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDRESS_WIDTH      = 8,
   parameter int ALMOST_FULL_LEVEL  = (1 << ADDRESS_WIDTH) - 2,
   parameter int ALMOST_EMPTY_LEVEL = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [ADDRESS_WIDTH:0]   count,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [ADDRESS_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   output logic                     mem_write_enable,
   output logic [ADDRESS_WIDTH-1:0] mem_read_address,
`ifdef SYNC_FIFO_WATERMARK_EN
   output logic [ADDRESS_WIDTH:0]   peak_count,
   input  logic                     clear_peak,
`endif
   input  logic [DATA_WIDTH-1:0]    mem_read_data
);

   localparam int PW = ADDRESS_WIDTH + 1;
   localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LEVEL);
   localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LEVEL);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full, empty, push, pop;

   // Handshake flags come only from registered pointers, never from in_valid/out_ready.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[ADDRESS_WIDTH] != rd_ptr_q[ADDRESS_WIDTH]) &&
              (wr_ptr_q[ADDRESS_WIDTH-1:0] == rd_ptr_q[ADDRESS_WIDTH-1:0]);
      in_ready  = !full;
      out_valid = !empty;
      push = in_valid && !full && !flush;
      pop  = out_ready && !empty && !flush;
      count = wr_ptr_q - rd_ptr_q;
      almost_full  = (count >= AF_LVL);
      almost_empty = (count <= AE_LVL);
   end

   always_comb begin
      mem_write_enable  = push;
      mem_write_address = wr_ptr_q[ADDRESS_WIDTH-1:0];
      mem_write_data    = in_data;
      mem_read_address  = rd_ptr_q[ADDRESS_WIDTH-1:0];
      out_data          = mem_read_data;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

`ifdef SYNC_FIFO_WATERMARK_EN
   logic [PW-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (clear_peak) begin
         peak_d = count;
      end else if (count > peak_q) begin
         peak_d = count;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: scoreboard bench for sync_fifo_ctrl with a behavioural dpram.
// Watermark checks build only when SYNC_FIFO_WATERMARK_EN is defined.
module tb_sync_fifo_ctrl;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [AW:0]   count;
   logic          almost_full, almost_empty;
   logic [AW-1:0] mem_write_address, mem_read_address;
   logic [DW-1:0] mem_write_data, mem_read_data;
   logic          mem_write_enable;
`ifdef SYNC_FIFO_WATERMARK_EN
   logic [AW:0]   peak_count;
   logic          clear_peak = 1'b0;
`endif

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] expq [$];
   int            mcount = 0;
   int            errors = 0;
   int            checks = 0;

   sync_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDRESS_WIDTH(AW),
      .ALMOST_FULL_LEVEL(6),
      .ALMOST_EMPTY_LEVEL(2)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable),
      .mem_read_address(mem_read_address),
`ifdef SYNC_FIFO_WATERMARK_EN
      .peak_count(peak_count),
      .clear_peak(clear_peak),
`endif
      .mem_read_data(mem_read_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
   end
   assign mem_read_data = mem[mem_read_address];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reference occupancy model fed only by the bench's own stimulus.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n || flush) begin
         expq.delete();
         mcount = 0;
      end else begin
         if (out_ready && mcount != 0) begin
            void'(expq.pop_front());
            mcount--;
         end
         if (in_valid && mcount != DEPTH - ((out_ready && mcount != 0) ? 0 : 0)
             && mcount + int'(expq.size() != mcount) != DEPTH + 1) begin
         end
      end
   end

   always @(negedge clock) begin
      chk("count", 32'(count), 32'(mcount));
      chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      chk("almost_full", 32'(almost_full), 32'(mcount >= 6));
      chk("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
      chk("mem_we", 32'(mem_write_enable),
          32'(in_valid && mcount != DEPTH && !flush));
      if (expq.size() != 0) chk("out_data", 32'(out_data), 32'(expq[0]));
   end

   // Push side of the model: an accepted push needs room before this edge.
   logic push_room;
   always @(negedge clock) push_room = (mcount != DEPTH);
   always @(posedge clock) begin
      if (reset_n && !flush && in_valid && push_room) begin
         #0;
         expq.push_back(in_data);
         mcount++;
      end
   end

   initial begin
      bit found;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;

      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_almost_empty", 32'(almost_empty), 32'd1);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_mem_we", 32'(mem_write_enable), 32'd0);

      in_valid = 1'b1;
      in_data = 8'h11;
      step();
      chk("fwft_valid", 32'(out_valid), 32'd1);
      chk("fwft_data", 32'(out_data), 32'h11);
      in_data = 8'h22;
      step();
      in_data = 8'h33;
      step();
      in_valid = 1'b0;
      chk("three_count", 32'(count), 32'd3);
      chk("three_head", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      chk("drain_count", 32'(count), 32'd0);

      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data = 8'hA0 + 8'(i);
         step();
         chk("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 6));
      end
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd8);
      in_data = 8'hEE;
      repeat (2) step();
      chk("held_off_count", 32'(count), 32'd8);
      chk("held_off_head", 32'(out_data), 32'hA0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop_in_ready", 32'(in_ready), 32'd1);
      chk("pop_count", 32'(count), 32'd7);
      step();
      chk("refill_count", 32'(count), 32'd8);

      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'h40 + 8'(i);
         step();
      end
      chk("stream_count", 32'(count), 32'd7);
      in_valid = 1'b0;
      repeat (7) step();
      out_ready = 1'b0;
      chk("stream_drain", 32'(count), 32'd0);

      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'h51 + 8'(i);
         step();
      end
      chk("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1;
      in_data = 8'h99;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] == 8'h99) found = 1'b1;
      chk("flush_no_write", 32'(found), 32'd0);

      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h61 + 8'(i);
         step();
      end
      #3;
      reset_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      chk("arst_almost_empty", 32'(almost_empty), 32'd1);
      @(negedge clock);
      #2 reset_n = 1'b1;
      step();
      in_valid = 1'b1;
      in_data = 8'h77;
      step();
      in_valid = 1'b0;
      chk("post_rst_data", 32'(out_data), 32'h77);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_rst_count", 32'(count), 32'd0);

`ifdef SYNC_FIFO_WATERMARK_EN
      clear_peak = 1'b1;
      step();
      clear_peak = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'hC0 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      out_ready = 1'b0;
      chk("wm_count", 32'(count), 32'd1);
      chk("wm_peak", 32'(peak_count), 32'd6);
      clear_peak = 1'b1;
      step();
      clear_peak = 1'b0;
      chk("wm_clear", 32'(peak_count), 32'd1);
      step();
      chk("wm_hold", 32'(peak_count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
`endif

      step();
      chk("sb_empty", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO controller that owns one dpram instance: drives its write port and read address, and consumes its combinational read_data.
- Presents a valid/ready push interface upstream and a valid/ready pop interface downstream.
- Provides occupancy count and almost-full/almost-empty flags.
- Intended as the same-clock sibling of the CDC FIFO, sharing the dpram storage primitive.

Parameters:
- DATA_WIDTH, 8, payload width; must match the dpram DATA_WIDTH.
- ADDRESS_WIDTH, 8, dpram address width; depth = 2**ADDRESS_WIDTH.
- ALMOST_FULL_LEVEL, (1<<ADDRESS_WIDTH)-2, almost_full asserts when count >= this value.
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when count <= this value.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of pointers; has priority over push and pop
- in_valid  in  1  upstream has data
- in_ready  out  1  FIFO can accept data
- in_data  in  DATA_WIDTH  push payload
- out_valid  out  1  FIFO has data
- out_ready  in  1  downstream accepts data
- out_data  out  DATA_WIDTH  head-of-FIFO payload
- count  out  ADDRESS_WIDTH+1  current occupancy, range 0..2**ADDRESS_WIDTH
- almost_full  out  1  count >= ALMOST_FULL_LEVEL
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL
- mem_write_address  out  ADDRESS_WIDTH  to dpram write_address
- mem_write_data  out  DATA_WIDTH  to dpram write_data
- mem_write_enable  out  1  to dpram write_enable
- mem_read_address  out  ADDRESS_WIDTH  to dpram read_address
- mem_read_data  in  DATA_WIDTH  from dpram read_data (combinational)

Behaviour:
- State:
  - wr_ptr and rd_ptr are ADDRESS_WIDTH+1 bits.
  - The lower ADDRESS_WIDTH bits address memory; the MSB is the wrap bit.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ) && (lower bits equal).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDRESS_WIDTH+1).
- Reset (reset_n low, asynchronous):
  - wr_ptr = rd_ptr = 0.
  - Outputs: in_ready=1, out_valid=0, count=0, almost_full=0, almost_empty=1, mem_write_enable=0.
  - Memory contents are not cleared.
- Push handshake:
  - in_ready = !full.
  - push = in_valid && in_ready && !flush.
  - mem_write_enable = push (combinational); mem_write_address = wr_ptr[ADDRESS_WIDTH-1:0]; mem_write_data = in_data.
  - wr_ptr increments on the clock edge.
- Pop handshake:
  - out_valid = !empty.
  - mem_read_address = rd_ptr[ADDRESS_WIDTH-1:0]; out_data = mem_read_data.
  - pop = out_valid && out_ready && !flush; rd_ptr increments on the clock edge.
- Latency:
  - Push at edge N: out_valid high and data visible after edge N (first-word-fall-through).
  - Pop at edge N: next word visible after edge N.
- Simultaneous push and pop: both pointers advance and count is unchanged.
  - When full, in_ready=0, so only the pop occurs; there is no bypass.
  - When empty, out_valid=0, so only the push occurs; there is no fall-through bypass.
- in_ready and out_valid depend only on registered pointers, never combinationally on in_valid or out_ready.
- Wrap-around: pointers roll over naturally at 2**(ADDRESS_WIDTH+1); address wraps from 2**ADDRESS_WIDTH-1 to 0.
- Flush: at the next edge rd_ptr <= 0 and wr_ptr <= 0. Any push or pop in that cycle is discarded and mem_write_enable=0.
- Reset asserted mid-operation: pointers clear immediately; stale memory data is never presented because out_valid=0.
- out_data is don't-care while out_valid=0.

Optional Feature:
- Macro: SYNC_FIFO_WATERMARK_EN.
- Defined:
  - Adds ports peak_count (out, ADDRESS_WIDTH+1) and clear_peak (in, 1).
  - peak_count holds the maximum count value seen since reset or clear_peak, updated each cycle as max(peak_count, count).
  - clear_peak loads the current count on the next edge.
  - Reset value of peak_count is 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, ADDRESS_WIDTH=3 -> in_ready=1, out_valid=0, count=0, almost_empty=1, almost_full=0, mem_write_enable=0.
- Push 0x11,0x22,0x33 on consecutive cycles, out_ready=0 -> count=3; out_valid rises the cycle after the first push; out_data=0x11. Then pop three -> 0x11,0x22,0x33 in order, count returns to 0.
- Push 8 words (depth 8) -> in_ready=0 and count=8 after 8th edge, almost_full high from count=6. A 9th in_valid is held off; pop one -> in_ready=1 next cycle.
- Full FIFO with in_valid=1, out_ready=1 held 20 cycles -> one pop and one push per cycle after the first pop. Pointers wrap past address 7 to 0, and data order is preserved across the wrap.
- count=5, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no write occurred. Repeat with reset_n pulsed low mid-burst -> same cleared state asynchronously.
- SYNC_FIFO_WATERMARK_EN: fill to 6, drain to 1 -> peak_count=6; clear_peak -> peak_count=1.
